// File: rtl/alu_test_sequencer.sv
// rtl/alu_test_sequencer.sv - LFSR-driven stimulus and golden-model checker for a registered ALU
// Drives A/B/Sel, then compares dut_out/dut_flags LATENCY+1 edges after each vector load.
module alu_test_sequencer #(
  parameter int          N           = 4,
  parameter int          LATENCY     = 2,
  parameter int          NUM_VECTORS = 16,
  parameter int unsigned SEED        = 8'h5A
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [3:0]   Sel,
  input  logic [N-1:0] dut_out,
  input  logic [3:0]   dut_flags,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   err_count,
  output logic         fail_valid,
  output logic [7:0]   first_fail_idx,
  output logic [7:0]   vec_idx
);

  localparam int W  = 2 * N;
  localparam int PW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  // Galois right-shift masks for maximal-length polynomials of width 2N.
  localparam logic [63:0] TAPS64 =
      (W == 4)  ? 64'h0000_000C :
      (W == 6)  ? 64'h0000_0030 :
      (W == 8)  ? 64'h0000_00B8 :
      (W == 10) ? 64'h0000_0240 :
      (W == 12) ? 64'h0000_0E08 :
      (W == 14) ? 64'h0000_3802 :
      (W == 16) ? 64'h0000_B400 :
      (W == 32) ? 64'h8020_0003 :
                  ((64'h1 << (W - 1)) | 64'h1);
  localparam logic [W-1:0] TAPS   = TAPS64[W-1:0];
  localparam logic [W-1:0] SEED_W = (W'(SEED) == '0) ? W'(1) : W'(SEED);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  lfsr;
  logic [PW-1:0] phase;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // Returns {V, C, Z, N, R}, matching the dut_flags bit order above the result.
  function automatic logic [N+3:0] golden(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [3:0] op);
    logic [N-1:0] r;
    logic         c;
    logic         v;
    logic [N:0]   sum;
    logic [W-1:0] prod;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    case (op)
      4'd0: begin
        r = sum[N-1:0];
        c = sum[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd2: begin
        r = prod[N-1:0];
        c = |prod[W-1:N];
      end
      4'd3: begin
        if (b == '0) begin
          r = '1;
          v = 1'b1;
        end else begin
          r = a / b;
        end
      end
      4'd4: begin
        if (b == '0) begin
          r = a;
          v = 1'b1;
        end else begin
          r = a % b;
        end
      end
      4'd5:    r = a & b;
      4'd6:    r = a | b;
      4'd7:    r = a ^ b;
      4'd8:    r = a << b;
      4'd9:    r = a >> b;
      default: r = '0;
    endcase
    return {v, c, (r == '0), r[N-1], r};
  endfunction

  logic [N+3:0] expected;
  logic         mismatch;
  logic         at_compare;
  logic         last_vec;
  logic [7:0]   err_next;

  assign expected   = golden(A, B, Sel);
  assign mismatch   = ({dut_flags, dut_out} != expected);
  assign at_compare = (phase == PW'(LATENCY));
  assign last_vec   = (vec_idx == 8'(NUM_VECTORS - 1));
  assign err_next   = (mismatch && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      lfsr           <= SEED_W;
      phase          <= '0;
      A              <= '0;
      B              <= '0;
      Sel            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
      vec_idx        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Vector 0 comes straight from the seed; the LFSR then holds vector 1.
            state          <= RUN;
            A              <= SEED_W[N-1:0];
            B              <= SEED_W[W-1:N];
            Sel            <= 4'd0;
            lfsr           <= lfsr_step(SEED_W);
            phase          <= '0;
            vec_idx        <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
          end
        end
        RUN: begin
          if (at_compare) begin
            err_count <= err_next;
            if (mismatch && !fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_idx <= vec_idx;
            end
            if (last_vec) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 8'd0);
            end else begin
              A       <= lfsr[N-1:0];
              B       <= lfsr[W-1:N];
              Sel     <= (Sel == 4'd9) ? 4'd0 : Sel + 4'd1;
              lfsr    <= lfsr_step(lfsr);
              vec_idx <= vec_idx + 8'd1;
              phase   <= '0;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_test_sequencer.sv
// tb/tb_alu_test_sequencer.sv - scoreboard bench: sequencer against a two-stage mock ALU
// A second instance with SEED 8'h60 hits B==0 on the DIV and MOD vectors.
module tb_alu_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic [3:0] a1, b1, sel1, out1, flags1;
  logic       busy1, done1, pass1, fv1;
  logic [7:0] err1, ffi1, vidx1;
  logic [3:0] a2, b2, sel2, out2, flags2;
  logic       busy2, done2, pass2, fv2;
  logic [7:0] err2, ffi2, vidx2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mode     = 0;

  alu_test_sequencer #(.N(4), .LATENCY(2), .NUM_VECTORS(16), .SEED(8'h5A)) dut (
    .clk(clk), .reset(reset), .start(start), .A(a1), .B(b1), .Sel(sel1),
    .dut_out(out1), .dut_flags(flags1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .first_fail_idx(ffi1), .vec_idx(vidx1)
  );

  alu_test_sequencer #(.N(4), .LATENCY(2), .NUM_VECTORS(16), .SEED(8'h60)) dut_b (
    .clk(clk), .reset(reset), .start(start), .A(a2), .B(b2), .Sel(sel2),
    .dut_out(out2), .dut_flags(flags2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .first_fail_idx(ffi2), .vec_idx(vidx2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU in integer arithmetic; returns {V, C, Z, N, R}.
  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] sel);
    int ua, ub, sa, sb, t;
    logic [3:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    r = 4'h0;
    c = 1'b0;
    v = 1'b0;
    case (sel)
      4'd0: begin t = ua + ub; r = 4'(t); c = (t > 15); t = sa + sb; v = (t > 7) || (t < -8); end
      4'd1: begin t = ua - ub; r = 4'(t); c = (ua < ub); t = sa - sb; v = (t > 7) || (t < -8); end
      4'd2: begin t = ua * ub; r = 4'(t); c = (t > 15); end
      4'd3: if (ub == 0) begin r = 4'hF; v = 1'b1; end else r = 4'(ua / ub);
      4'd4: if (ub == 0) begin r = a; v = 1'b1; end else r = 4'(ua % ub);
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: r = (ub >= 4) ? 4'h0 : 4'((ua << ub) & 15);
      4'd9: r = (ub >= 4) ? 4'h0 : 4'(ua >> ub);
      default: r = 4'h0;
    endcase
    return {v, c, (r == 4'h0), r[3], r};
  endfunction

  function automatic logic [7:0] fault(input logic [7:0] res, input logic [3:0] sel,
                                       input logic [7:0] vi, input int m);
    logic [7:0] f;
    f = res;
    if (m == 1 && sel == 4'd3) f[0] = ~f[0];
    if (m == 2 && vi == 8'd0)  f[5] = ~f[5];
    return f;
  endfunction

  logic [3:0] ma = '0, mb = '0, ms = '0, na = '0, nb = '0, ns = '0;
  logic [7:0] mv = '0, mr = '0, mr2 = '0, nr = '0;

  always @(posedge clk) begin
    ma  <= a1;  mb <= b1;  ms <= sel1;  mv <= vidx1;
    mr  <= fault(ref_alu(ma, mb, ms), ms, mv, mode);
    mr2 <= mr;
    na  <= a2;  nb <= b2;  ns <= sel2;
    nr  <= ref_alu(na, nb, ns);
  end

  assign {flags1, out1} = (mode == 3) ? mr2 : mr;
  assign {flags2, out2} = nr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] idx;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
  } vec_t;

  typedef struct {
    int         done_cyc;
    logic       exact;
    logic [7:0] err;
    logic       fv;
    logic [7:0] ffi;
    logic       pass;
  } res_t;

  vec_t vq[$];
  res_t rq[$];

  // LFSR states from seed 8'h5A (Galois mask 8'hB8), worked out by hand.
  logic [7:0] tab [16] = '{8'h5A, 8'h2D, 8'hAE, 8'h57, 8'h93, 8'hF1, 8'hC0, 8'h60,
                           8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'hB9, 8'hE4, 8'h72};

  task automatic push_run(input int s, input int m);
    vec_t e;
    res_t r;
    for (int k = 0; k < 16; k++) begin
      e.idx = 8'(k);
      e.a   = tab[k][3:0];
      e.b   = tab[k][7:4];
      e.sel = 4'(k % 10);
      vq.push_back(e);
    end
    r.done_cyc = s + 48;
    r.exact = 1'b1; r.err = 8'd0; r.fv = 1'b0; r.ffi = 8'd0; r.pass = 1'b1;
    case (m)
      1: begin r.err = 8'd2; r.fv = 1'b1; r.ffi = 8'd3; r.pass = 1'b0; end
      2: begin r.err = 8'd1; r.fv = 1'b1; r.ffi = 8'd0; r.pass = 1'b0; end
      3: begin r.exact = 1'b0; r.fv = 1'b1; r.pass = 1'b0; end
      default: ;
    endcase
    rq.push_back(r);
  endtask

  logic       pbusy = 1'b0, pdone = 1'b0, pbusy2 = 1'b0, pdone2 = 1'b0;
  logic [7:0] pidx = '0, pidx2 = '0;
  int         vcyc = 0;

  always @(negedge clk) begin
    vec_t e;
    res_t r;
    if (busy1 && (!pbusy || vidx1 != pidx)) begin
      if (pbusy) chk("vec_period", cyc - vcyc, 3);
      vcyc = cyc;
      if (vq.size() == 0) begin
        chk("vec_unexpected", 1, 0);
      end else begin
        e = vq.pop_front();
        chk("vec_idx", vidx1, e.idx);
        chk("vec_A", a1, e.a);
        chk("vec_B", b1, e.b);
        chk("vec_Sel", sel1, e.sel);
      end
    end
    if (done1 && !pdone) begin
      if (rq.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        r = rq.pop_front();
        chk("done_cycle", cyc, r.done_cyc);
        chk("done_busy", busy1, 0);
        if (r.exact) begin
          chk("err_count", err1, r.err);
          chk("first_fail_idx", ffi1, r.ffi);
        end else begin
          chk("err_nonzero", int'(err1 != 8'd0), 1);
        end
        chk("fail_valid", fv1, r.fv);
        chk("pass", pass1, r.pass);
      end
    end
    pbusy = busy1;
    pdone = done1;
    pidx  = vidx1;
  end

  always @(negedge clk) begin
    if (busy2 && (!pbusy2 || vidx2 != pidx2)) begin
      if (vidx2 == 8'd3) begin
        chk("div0_A", a2, 12); chk("div0_B", b2, 0); chk("div0_Sel", sel2, 3);
      end
      if (vidx2 == 8'd4) begin
        chk("mod0_A", a2, 6); chk("mod0_B", b2, 0); chk("mod0_Sel", sel2, 4);
      end
    end
    if (done2 && !pdone2) begin
      chk("zero_div_pass", pass2, 1);
      chk("zero_div_err", err2, 0);
      chk("zero_div_fv", fv2, 0);
    end
    pbusy2 = busy2;
    pdone2 = done2;
    pidx2  = vidx2;
  end

  task automatic chk_reset_state();
    chk("rst_A", a1, 0);       chk("rst_B", b1, 0);       chk("rst_Sel", sel1, 0);
    chk("rst_busy", busy1, 0); chk("rst_done", done1, 0); chk("rst_pass", pass1, 0);
    chk("rst_err", err1, 0);   chk("rst_fv", fv1, 0);     chk("rst_ffi", ffi1, 0);
    chk("rst_vidx", vidx1, 0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(done1 && !busy1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", int'(n < budget), 1);
    @(posedge clk);
  endtask

  task automatic run_once(input int m);
    int s;
    mode = m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    start = 1'b0;
    push_run(s, m);
    wait_done(200);
  endtask

  initial begin
    int s;
    int n;
    reset = 1'b1;
    start = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_state();
    @(negedge clk) reset = 1'b1;

    run_once(0);
    run_once(1);
    run_once(2);
    run_once(3);

    // Reset during vector 5, then a fresh run must replay the same sequence.
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    start = 1'b0;
    push_run(s, 0);
    n = 0;
    while (vidx1 != 8'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec5", int'(n < 100), 1);
    #2 reset = 1'b0;
    #1 chk_reset_state();
    vq.delete();
    rq.delete();
    @(negedge clk) reset = 1'b1;
    run_once(0);

    // Start held high: ignored during RUN, restarts on the edge after done.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    push_run(s, 0);
    push_run(s + 49, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("hold_busy", busy1, 1);
    chk("hold_vidx", vidx1, 10);
    repeat (25) @(posedge clk);
    #1 chk("restart_vidx", vidx1, 2);
    @(negedge clk) start = 1'b0;
    wait_done(200);

    repeat (2) @(posedge clk);
    chk("vq_empty", vq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
